// File: rtl/lsu_mem_master_if.sv
// Request, response and data-memory signals shared by the load/store unit and its environment.
// master = the LSU's view, slave = the pipeline-plus-memory view.
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-addressed data memory: sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them.
module lsu_mem_master #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    lsu_mem_master_if.master   bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WRITE, ST_RESP} state_t;

    localparam logic [29:0] MEM_WORDS_IDX = 30'(MEM_WORDS);

    state_t      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        lat_we_q, lat_we_d;
    logic [1:0]  lat_size_q, lat_size_d;
    logic        lat_unsigned_q, lat_unsigned_d;
    logic [1:0]  lat_off_q, lat_off_d;
    logic [31:0] lat_wdata_q, lat_wdata_d;
    logic        lat_err_q, lat_err_d;

    logic accept;
    logic misalign;
    logic req_err;

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   res = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Halfword lane comes from off[1] alone, which also realigns odd halfword addresses.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] off);
        logic [31:0] res;
        res = word;
        if (size == 2'b00) begin
            res[{off, 3'b000} +: 8] = wdata[7:0];
        end else if (off[1]) begin
            res[31:16] = wdata[15:0];
        end else begin
            res[15:0] = wdata[15:0];
        end
        return res;
    endfunction

    assign accept = bus.req_valid && req_ready_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign req_err = (bus.req_size == 2'b11) || (bus.req_addr[31:2] >= MEM_WORDS_IDX) || misalign;

    always_comb begin
        state_d        = state_q;
        req_ready_d    = req_ready_q;
        resp_valid_d   = resp_valid_q;
        resp_rdata_d   = resp_rdata_q;
        resp_err_d     = resp_err_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_we_d       = mem_we_q;
        lat_we_d       = lat_we_q;
        lat_size_d     = lat_size_q;
        lat_unsigned_d = lat_unsigned_q;
        lat_off_d      = lat_off_q;
        lat_wdata_d    = lat_wdata_q;
        lat_err_d      = lat_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d        = ST_ACCESS;
                    req_ready_d    = 1'b0;
                    lat_we_d       = bus.req_we;
                    lat_size_d     = bus.req_size;
                    lat_unsigned_d = bus.req_unsigned;
                    lat_off_d      = bus.req_addr[1:0];
                    lat_wdata_d    = bus.req_wdata;
                    lat_err_d      = req_err;
                    mem_addr_d     = {2'b00, bus.req_addr[31:2]};
                    // Word stores write during the access cycle itself.
                    if (bus.req_we && (bus.req_size == 2'b10) && !req_err) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = bus.req_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                mem_we_d = 1'b0;
                if (!lat_err_q && lat_we_q && (lat_size_q != 2'b10)) begin
                    state_d     = ST_WRITE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = store_merge(bus.mem_rdata, lat_wdata_q, lat_size_q, lat_off_q);
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = lat_err_q;
                    resp_rdata_d = (!lat_err_q && !lat_we_q) ?
                                   load_extend(bus.mem_rdata, lat_size_q, lat_off_q, lat_unsigned_q) :
                                   32'h0;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                mem_we_d     = 1'b0;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'h0;
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                mem_we_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 32'h0;
            resp_err_q     <= 1'b0;
            mem_addr_q     <= 32'h0;
            mem_wdata_q    <= 32'h0;
            mem_we_q       <= 1'b0;
            lat_we_q       <= 1'b0;
            lat_size_q     <= 2'b00;
            lat_unsigned_q <= 1'b0;
            lat_off_q      <= 2'b00;
            lat_wdata_q    <= 32'h0;
            lat_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_we_q       <= mem_we_d;
            lat_we_q       <= lat_we_d;
            lat_size_q     <= lat_size_d;
            lat_unsigned_q <= lat_unsigned_d;
            lat_off_q      <= lat_off_d;
            lat_wdata_q    <= lat_wdata_d;
            lat_err_q      <= lat_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: a 1024-word memory model plus a scoreboard of expected responses.
// Cycle 1 after the accept edge is the access cycle; loads respond in cycle 2, sub-word stores in cycle 3.
module tb_lsu_mem_master;
    logic clk;
    logic rst;

    lsu_mem_master_if bus ();

    lsu_mem_master #(.MEM_WORDS(1024)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          pulses;
        logic [31:0] index;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [0:1023];
    int          we_count;
    int          resp_count;
    int          req_done;
    int          checks;
    int          fails;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rdata = (bus.mem_addr < 32'd1024) ? mem[bus.mem_addr[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (bus.mem_we && (bus.mem_addr < 32'd1024)) mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            we_count   <= 0;
            resp_count <= 0;
        end else begin
            if (bus.mem_we) we_count <= we_count + 1;
            if (bus.resp_valid) resp_count <= resp_count + 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: push the expectation, drive it, then wait a bounded number of cycles for the response.
    task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_rdata, input logic exp_err,
                                  input int exp_lat, input string tag);
        exp_t        e;
        exp_t        got_e;
        int          we_before;
        int          cyc;
        logic [31:0] addr_seen;
        bit          got;
        e.rdata  = exp_rdata;
        e.err    = exp_err;
        e.lat    = exp_lat;
        e.pulses = (we && !exp_err) ? 1 : 0;
        e.index  = {2'b00, addr[31:2]};
        sb_q.push_back(e);

        @(negedge clk);
        check_output({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        we_before        = we_count;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_addr     = 32'hFFFF_FFFC;
        bus.req_wdata    = 32'h5A5A_5A5A;

        got       = 1'b0;
        cyc       = 0;
        addr_seen = bus.mem_addr;
        for (int c = 1; c <= 8 && !got; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (bus.resp_valid) begin
                got = 1'b1;
                cyc = c;
            end
        end

        if (!got) begin
            checks++;
            fails++;
            $error("[TB] FAIL %s_timeout: observed no resp_valid expected response within 8 cycles", tag);
            void'(sb_q.pop_front());
        end else begin
            got_e = sb_q.pop_front();
            req_done++;
            check_output({tag, "_rdata"}, bus.resp_rdata, got_e.rdata);
            check_output({tag, "_err"}, 32'(bus.resp_err), 32'(got_e.err));
            check_output({tag, "_latency"}, 32'(cyc), 32'(got_e.lat));
            check_output({tag, "_mem_addr"}, addr_seen, got_e.index);
            check_output({tag, "_we_pulses"}, 32'(we_count - we_before), 32'(got_e.pulses));
        end

        @(posedge clk);
        #1;
        check_output({tag, "_resp_drop"}, 32'(bus.resp_valid), 32'd0);
        check_output({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        req_done = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        check_output("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_output("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_output("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check_output("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check_output("rst_mem_addr", bus.mem_addr, 32'h0);
        check_output("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check_output("rst_mem_we", 32'(bus.mem_we), 32'd0);

        $display("[TB] word store and load");
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw_10");
        check_output("sw_10_mem", mem[4], 32'hDEADBEEF);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "lw_10");

        $display("[TB] sub-word read-modify-write");
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 2, "sw_init");
        apply_stimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h123456AA, 32'h0, 1'b0, 3, "sb_13");
        check_output("sb_13_mem", mem[4], 32'hAA223344);
        apply_stimulus(1'b1, 2'b01, 1'b0, 32'h16, 32'h7777BEEF, 32'h0, 1'b0, 3, "sh_16");
        check_output("sh_16_mem", mem[5], 32'hBEEF0000);

        $display("[TB] loads with extension");
        apply_stimulus(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFFAA, 1'b0, 2, "lb_13");
        apply_stimulus(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h000000AA, 1'b0, 2, "lbu_13");
        apply_stimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFAA22, 1'b0, 2, "lh_12");
        apply_stimulus(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000AA22, 1'b0, 2, "lhu_12");
        apply_stimulus(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h00000033, 1'b0, 2, "lb_11");
        apply_stimulus(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h00003344, 1'b0, 2, "lh_10");
        apply_stimulus(1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 32'hFFFFBEEF, 1'b0, 2, "lh_16");

        $display("[TB] faulting requests");
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 2, "lw_oob");
        apply_stimulus(1'b1, 2'b10, 1'b0, 32'h0FFC, 32'hCAFEF00D, 32'h0, 1'b0, 2, "sw_last");
        check_output("sw_last_mem", mem[1023], 32'hCAFEF00D);
        apply_stimulus(1'b1, 2'b00, 1'b0, 32'h1003, 32'h000000FF, 32'h0, 1'b1, 2, "sb_oob");
        apply_stimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'h99999999, 32'h0, 1'b1, 2, "st_size11");
        check_output("size11_mem", mem[4], 32'hAA223344);
        apply_stimulus(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 2, "ld_size11");

        $display("[TB] misaligned accesses");
`ifdef LSU_MISALIGN_TRAP_EN
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 2, "lw_12");
        apply_stimulus(1'b1, 2'b01, 1'b0, 32'h11, 32'h00005566, 32'h0, 1'b1, 2, "sh_11");
        check_output("sh_11_mem", mem[4], 32'hAA223344);
`else
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'hAA223344, 1'b0, 2, "lw_12");
        apply_stimulus(1'b1, 2'b01, 1'b0, 32'h11, 32'h00005566, 32'h0, 1'b0, 3, "sh_11");
        check_output("sh_11_mem", mem[4], 32'hAA225566);
`endif

        $display("[TB] reset during write cycle");
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b01;
        bus.req_addr  = 32'h14;
        bus.req_wdata = 32'h00005555;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("abort_we_in_write", 32'(bus.mem_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_output("abort_we_drop", 32'(bus.mem_we), 32'd0);
        check_output("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_output("abort_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        check_output("abort_ready", 32'(bus.req_ready), 32'd1);
        check_output("abort_mem", mem[5], 32'hBEEF0000);
        apply_stimulus(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hBEEF0000, 1'b0, 2, "lw_after_abort");
        check_output("resp_count", 32'(resp_count), 32'd1);
        check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
